uart_receiver: RTL
==================

// Module: uart_receiver
//
// PURPOSE
// Receive half of the UART: 16x-oversampled serial-to-byte receiver with its own baud tick
// generator, input synchroniser, framing-error check and a first-word-fall-through receive FIFO.
// Pairs with the transmitter at the far end of the link. Default link: 9600 baud, 8N1, 50 MHz clk.
// Host logic pops bytes with rd_uart/rx_empty. Error conditions are reported on sticky flags.
//
// PARAMETERS
// DBIT     8    data bits per frame, sent LSB first
// SB_tck   16   oversample ticks per stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2)
// DVSR     326  clk cycles per oversample tick = 50M/(16*baud)
// DVSR_BIT 9    width of the tick divider counter
// FIFO_W   5    FIFO address width; depth = 2**FIFO_W
//
// PORTS
// clk        in   1     system clock
// reset      in   1     asynchronous, active-high reset
// rx         in   1     serial line, idle high, asynchronous to clk
// rd_uart    in   1     pop head byte; ignored while rx_empty=1
// clr_err    in   1     one-cycle pulse that clears frame_err and overrun
// r_data     out  DBIT  FIFO head byte, valid while rx_empty=0 (FWFT)
// rx_empty   out  1     FIFO empty
// rx_full    out  1     FIFO full
// frame_err  out  1     sticky: a frame had its stop bit sampled low
// overrun    out  1     sticky: a good byte arrived while the FIFO was full
//
// BEHAVIOUR
// - Reset values: rx_empty=1, rx_full=0, frame_err=0, overrun=0, r_data=0. FSM=IDLE.
//   Synchroniser flops reset to 1. Divider, tick, bit and shift counters reset to 0.
// - Tick: free-running counter 0..DVSR-1. tck pulses for 1 clk when count==DVSR-1, then wraps to 0.
// - rx passes through a 2-flop synchroniser to give rx_s. Synchroniser latency is 2 clk.
// - FSM states, sample counter s, bit counter n, shift register b:
//   IDLE : on rx_s==0, go to START with s=0. No tck is needed to leave IDLE.
//   START: on each tck, s++. When s==7 (mid start bit):
//          rx_s==0 -> DATA with s=0, n=0
//          rx_s==1 -> IDLE (glitch rejected, nothing written)
//   DATA : on each tck, s++. When s==15: b={rx_s,b[DBIT-1:1]}, s=0, n++.
//          When n==DBIT-1 on that sample -> STOP.
//   STOP : on each tck, s++. When s==SB_tck-1: evaluate the frame, go to IDLE.
// - Frame evaluation in the STOP evaluation cycle:
//   rx_s==1 -> rx_done. b is written to the FIFO if not full; if full, overrun<=1 and the byte
//              is dropped.
//   rx_s==0 -> frame_err<=1, byte discarded, no FIFO write.
// - FIFO write takes effect at the clock edge. rx_empty falls and r_data is valid the next cycle.
// - rd_uart with rx_empty=0 pops the head. The new head or empty status shows the next cycle.
// - Simultaneous write and read:
//   FIFO full  -> both occur, occupancy unchanged, no overrun.
//   FIFO empty -> write occurs, read ignored.
// - Pointers wrap modulo 2**FIFO_W. full/empty come from pointer equality plus a registered
//   full/empty state; no FIFO slot is sacrificed.
// - clr_err clears both sticky flags. A set in the same cycle as clr_err wins: flag stays 1.
// - Asynchronous reset mid-frame aborts the frame immediately, empties the FIFO and returns the
//   FSM to IDLE. After release, a new frame is accepted only on a fresh falling edge of rx_s.
// - A line held low (break) is not re-armed in IDLE until rx_s has returned high.
//
// TESTING (simulate with DVSR=4, DVSR_BIT=3, FIFO_W=2; 1 bit = 64 clk)
// 1. Send 0x55, 8N1 -> rx_empty falls within 2 clk after stop mid-point; r_data=0x55;
//    rd_uart pulse -> rx_empty=1.
// 2. rx low for 20 clk then high -> FSM returns to IDLE; no write; rx_empty stays 1;
//    frame_err stays 0.
// 3. Send 0xA3 with stop bit 0 -> frame_err=1, rx_empty=1. clr_err pulse -> frame_err=0.
// 4. Send 0x01..0x05 back-to-back, no reads -> rx_full=1 after 4 bytes, overrun=1 after the 5th;
//    reads return 0x01..0x04, then rx_empty=1.
// 5. Read and write in the same cycle while the FIFO is full -> rx_full stays 1; overrun stays 0;
//    data order preserved.
// 6. Assert reset at bit 4 of 0xC3 -> all outputs return to reset values. The next frame 0x3C
//    is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: host-side bundle of the UART receiver (serial in, FIFO pop, sticky error flags)
// rx        serial line, idle high
// rd_uart   pop FIFO head, clr_err clears frame_err/overrun
// r_data    FIFO head (FWFT), rx_empty/rx_full FIFO status
// frame_err stop bit sampled low, overrun good byte dropped on full FIFO
interface uart_rx_if #(parameter int DBIT = 8);
  logic rx, rd_uart, clr_err;
  logic [DBIT-1:0] r_data;
  logic rx_empty, rx_full, frame_err, overrun;
  modport master(output rx, rd_uart, clr_err, input r_data, rx_empty, rx_full, frame_err, overrun);
  modport slave(input rx, rd_uart, clr_err, output r_data, rx_empty, rx_full, frame_err, overrun);
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled UART receiver with baud tick, synchroniser, framing check and FWFT FIFO
// clk, reset  system clock, asynchronous active-high reset
// u           uart_rx_if slave: rx in, rd_uart/clr_err in, r_data/rx_empty/rx_full/frame_err/overrun out
module uart_receiver #(
  parameter int DBIT = 8,
  parameter int SB_tck = 16,
  parameter int DVSR = 326,
  parameter int DVSR_BIT = 9,
  parameter int FIFO_W = 5
) (
  input logic clk,
  input logic reset,
  uart_rx_if.slave u
);
  localparam int SW = $clog2(SB_tck) > 4 ? $clog2(SB_tck) : 4;
  localparam int NW = $clog2(DBIT) > 0 ? $clog2(DBIT) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t st;
  logic [DVSR_BIT-1:0] cnt;
  logic [1:0] sy;
  logic tck, rx_s, armed, eval, done, rd, we, empty, full, fe, ovr;
  logic [SW-1:0] s;
  logic [NW-1:0] n;
  logic [DBIT-1:0] b;
  logic [FIFO_W-1:0] wp, rp;
  logic [DBIT-1:0] mem [2**FIFO_W];
  assign tck = cnt == DVSR_BIT'(DVSR - 1);
  assign rx_s = sy[1];
  assign eval = st == STOP && tck && s == SW'(SB_tck - 1);
  assign done = eval && rx_s;
  assign rd = u.rd_uart && !empty;
  // a full FIFO still accepts the byte when the same cycle frees a slot
  assign we = done && (!full || rd);
  // armed blocks re-triggering on a held-low line until rx_s has been seen high again
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      sy <= 2'b11;
      st <= IDLE;
      armed <= 1'b0;
      s <= '0;
      n <= '0;
      b <= '0;
    end else begin
      cnt <= tck ? '0 : cnt + 1'b1;
      sy <= {sy[0], u.rx};
      case (st)
        IDLE: if (rx_s) armed <= 1'b1;
              else if (armed) begin
                st <= START;
                s <= '0;
                armed <= 1'b0;
              end
        START: if (tck) begin
                 if (s == SW'(7)) begin
                   st <= rx_s ? IDLE : DATA;
                   s <= '0;
                   n <= '0;
                 end else s <= s + 1'b1;
               end
        DATA: if (tck) begin
                if (s == SW'(15)) begin
                  s <= '0;
                  b <= {rx_s, b[DBIT-1:1]};
                  n <= n + 1'b1;
                  if (n == NW'(DBIT - 1)) st <= STOP;
                end else s <= s + 1'b1;
              end
        STOP: if (tck) begin
                if (s == SW'(SB_tck - 1)) st <= IDLE;
                else s <= s + 1'b1;
              end
        default: st <= IDLE;
      endcase
    end
  always_ff @(posedge clk)
    if (we) mem[wp] <= b;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      empty <= 1'b1;
      full <= 1'b0;
      fe <= 1'b0;
      ovr <= 1'b0;
    end else begin
      wp <= wp + FIFO_W'(we);
      rp <= rp + FIFO_W'(rd);
      if (we != rd) begin
        empty <= rd && rp + 1'b1 == wp;
        full <= we && wp + 1'b1 == rp;
      end
      fe <= (eval && !rx_s) || (fe && !u.clr_err);
      ovr <= (done && full && !rd) || (ovr && !u.clr_err);
    end
  assign u.r_data = empty ? '0 : mem[rp];
  assign u.rx_empty = empty;
  assign u.rx_full = full;
  assign u.frame_err = fe;
  assign u.overrun = ovr;
endmodule
